// File: rtl/vga_pkg.sv
// Shared VGA timing package.
// Holds the default 640x480@60 timing, the derived line/frame totals, the raster
// counter width and the sync generator state encoding. The on-screen printers
// express their start-row/size parameters against VGA_V_VISIBLE from here.
package vga_pkg;

    // Raster counters are 10 bits wide; an axis total may not exceed 2**10.
    localparam int unsigned VGA_POS_W   = 10;
    localparam int unsigned VGA_POS_MAX = 1 << VGA_POS_W;

    localparam int unsigned VGA_H_VISIBLE = 640;
    localparam int unsigned VGA_H_FRONT   = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BACK    = 48;

    localparam int unsigned VGA_V_VISIBLE = 480;
    localparam int unsigned VGA_V_FRONT   = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BACK    = 33;

    // Length of one axis: visible area plus front porch, sync and back porch.
    function automatic int unsigned axis_total(input int unsigned visible,
                                               input int unsigned front,
                                               input int unsigned sync,
                                               input int unsigned back);
        return visible + front + sync + back;
    endfunction

    localparam int unsigned VGA_H_TOTAL =
        axis_total(VGA_H_VISIBLE, VGA_H_FRONT, VGA_H_SYNC, VGA_H_BACK);
    localparam int unsigned VGA_V_TOTAL =
        axis_total(VGA_V_VISIBLE, VGA_V_FRONT, VGA_V_SYNC, VGA_V_BACK);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StRun      = 2'd1,
        StStopping = 2'd2
    } vga_state_e;

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle between the sync generator and the display printers.
//   en          run request (consumer -> generator)
//   hsinc/vsinc sync outputs, polarity fixed by the generator
//   draw        inside the visible area
//   h_pos/v_pos raster coordinates
//   line_start  pulse at column 0; frame_start pulse at (0,0)
//   running     generator is producing frames
// master: the generator side; slave: a consumer that also owns the run request.
interface vga_sync_gen_if;
    import vga_pkg::*;

    logic                 en;
    logic                 hsinc;
    logic                 vsinc;
    logic                 draw;
    logic [VGA_POS_W-1:0] h_pos;
    logic [VGA_POS_W-1:0] v_pos;
    logic                 line_start;
    logic                 frame_start;
    logic                 running;

    modport master (
        input  en,
        output hsinc, vsinc, draw, h_pos, v_pos, line_start, frame_start, running
    );

    modport slave (
        output en,
        input  hsinc, vsinc, draw, h_pos, v_pos, line_start, frame_start, running
    );

endinterface

// File: rtl/sync_axis_counter.sv
// One raster axis: a wrap counter plus registered decode of its active and sync
// windows. The decodes are computed from the next count so they land in the same
// cycle as the count they describe.
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   run_i          generator is live this cycle (counter may advance)
//   run_next_i     generator is live next cycle (otherwise count clears to 0)
//   inc_i          advance request (1 for horizontal, line wrap for vertical)
//   pos_o          current position, 0..Total-1
//   active_o       pos_o < Visible
//   sync_o         pos_o inside the sync window (active-high)
//   start_o        pos_o == 0 while live
//   last_o         pos_o == Total-1
module sync_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned Visible = VGA_H_VISIBLE,
    parameter int unsigned Front   = VGA_H_FRONT,
    parameter int unsigned Sync    = VGA_H_SYNC,
    parameter int unsigned Back    = VGA_H_BACK
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 run_i,
    input  logic                 run_next_i,
    input  logic                 inc_i,
    output logic [VGA_POS_W-1:0] pos_o,
    output logic                 active_o,
    output logic                 sync_o,
    output logic                 start_o,
    output logic                 last_o
);

    localparam int unsigned Total = axis_total(Visible, Front, Sync, Back);

    typedef logic [VGA_POS_W-1:0] pos_t;
    // One extra bit so a window ending exactly at 1024 still compares correctly.
    typedef logic [VGA_POS_W:0]   cmp_t;

    localparam pos_t LastPos   = pos_t'(Total - 1);
    localparam cmp_t ActiveEnd = cmp_t'(Visible);
    localparam cmp_t SyncBeg   = cmp_t'(Visible + Front);
    localparam cmp_t SyncEnd   = cmp_t'(Visible + Front + Sync);

    if (Total > VGA_POS_MAX) begin : g_total_check
        $error("sync_axis_counter: axis total %0d exceeds the counter range", Total);
    end

    pos_t pos_q, pos_d;
    cmp_t pos_ext;
    logic active_q, active_d;
    logic sync_q, sync_d;
    logic start_q, start_d;

    assign last_o = (pos_q == LastPos);

    always_comb begin
        pos_d = pos_q;
        if (!run_next_i) begin
            pos_d = '0;
        end else if (run_i && inc_i) begin
            pos_d = last_o ? '0 : pos_q + pos_t'(1);
        end
        pos_ext  = {1'b0, pos_d};
        active_d = run_next_i && (pos_ext < ActiveEnd);
        sync_d   = run_next_i && (pos_ext >= SyncBeg) && (pos_ext < SyncEnd);
        start_d  = run_next_i && (pos_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pos_q    <= '0;
            active_q <= 1'b0;
            sync_q   <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            pos_q    <= pos_d;
            active_q <= active_d;
            sync_q   <= sync_d;
            start_q  <= start_d;
        end
    end

    assign pos_o    = pos_q;
    assign active_o = active_q;
    assign sync_o   = sync_q;
    assign start_o  = start_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator.
// Produces hsinc/vsinc, draw and raster coordinates from the pixel clock. A
// start/stop FSM only ever leaves a frame at its last pixel, so consumers never
// see a truncated frame.
//   pixelclock  pixel clock, all logic on its rising edge
//   resetn      asynchronous active-low reset
//   vga         timing bundle (master side): en in; syncs, draw, positions,
//               line_start, frame_start, running out
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE   = VGA_H_VISIBLE,
    parameter int unsigned H_FRONT     = VGA_H_FRONT,
    parameter int unsigned H_SYNC      = VGA_H_SYNC,
    parameter int unsigned H_BACK      = VGA_H_BACK,
    parameter int unsigned V_VISIBLE   = VGA_V_VISIBLE,
    parameter int unsigned V_FRONT     = VGA_V_FRONT,
    parameter int unsigned V_SYNC      = VGA_V_SYNC,
    parameter int unsigned V_BACK      = VGA_V_BACK,
    parameter bit          SYNC_ACTIVE = 1'b0
) (
    input  logic           pixelclock,
    input  logic           resetn,
    vga_sync_gen_if.master vga
);

    vga_state_e state_q, state_d;
    logic       run, run_next;
    logic       h_last, v_last;
    logic       h_active, v_active;
    logic       h_sync, v_sync;
    logic       h_start, v_start;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (vga.en) state_d = StRun;
            end
            StRun: begin
                if (!vga.en) state_d = StStopping;
            end
            StStopping: begin
                // A renewed run request wins even on the final pixel.
                if (vga.en) begin
                    state_d = StRun;
                end else if (h_last && v_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge pixelclock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    assign run      = (state_q != StIdle);
    assign run_next = (state_d != StIdle);

    sync_axis_counter #(
        .Visible (H_VISIBLE),
        .Front   (H_FRONT),
        .Sync    (H_SYNC),
        .Back    (H_BACK)
    ) u_h_axis (
        .clk_i      (pixelclock),
        .rst_ni     (resetn),
        .run_i      (run),
        .run_next_i (run_next),
        .inc_i      (1'b1),
        .pos_o      (vga.h_pos),
        .active_o   (h_active),
        .sync_o     (h_sync),
        .start_o    (h_start),
        .last_o     (h_last)
    );

    // Rows advance on the cycle the column wraps.
    sync_axis_counter #(
        .Visible (V_VISIBLE),
        .Front   (V_FRONT),
        .Sync    (V_SYNC),
        .Back    (V_BACK)
    ) u_v_axis (
        .clk_i      (pixelclock),
        .rst_ni     (resetn),
        .run_i      (run),
        .run_next_i (run_next),
        .inc_i      (h_last),
        .pos_o      (vga.v_pos),
        .active_o   (v_active),
        .sync_o     (v_sync),
        .start_o    (v_start),
        .last_o     (v_last)
    );

    // Every term below is a flop from the same edge, so outputs stay aligned.
    assign vga.hsinc       = h_sync ? SYNC_ACTIVE : !SYNC_ACTIVE;
    assign vga.vsinc       = v_sync ? SYNC_ACTIVE : !SYNC_ACTIVE;
    assign vga.draw        = h_active && v_active;
    assign vga.line_start  = h_start;
    assign vga.frame_start = h_start && v_start;
    assign vga.running     = run;

endmodule
